// File: rtl/load_store_unit.sv
// Load/store unit between the EX/MEM stage and a 64-bit doubleword data memory.
// Handles RV64 B/H/W/D loads with sign/zero extension and stores, using
// read-modify-write for sub-doubleword stores.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses report an
// error instead of being forced to natural alignment).
module load_store_unit #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data
);

  typedef enum logic [1:0] {StIdle, StRdWait, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, wdata_q, rd_q;
  logic [2:0]  funct3_q, cnt_q;
  logic        write_q, err_q;

  logic        accept, lat_done;
  logic        req_illegal, req_misalign, req_err;
  logic [2:0]  req_mask;
  logic [63:0] req_eff_addr;

  // Request decode: low-address mask covers the bytes inside one access.
  assign req_mask     = 3'((4'd1 << req_funct3[1:0]) - 4'd1);
  assign req_illegal  = (req_funct3 == 3'b111) || (req_write && req_funct3[2]);
  assign req_misalign = |(req_addr[2:0] & req_mask);
`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err      = req_illegal || req_misalign;
  assign req_eff_addr = req_addr;
`else
  assign req_err      = req_illegal;
  assign req_eff_addr = {req_addr[63:3], req_addr[2:0] & ~req_mask};
`endif

  assign accept   = req_valid && (state_q == StIdle);
  assign lat_done = (cnt_q == 3'(RD_LATENCY - 1));

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err)                                state_d = StResp;
          else if (req_write && req_funct3 == 3'b011) state_d = StWr;
          else                                        state_d = StRdWait;
        end
      end
      StRdWait: if (lat_done) state_d = write_q ? StWr : StResp;
      StWr:     state_d = StResp;
      StResp:   state_d = StIdle;
    endcase
  end

  // Request latch, read-latency counter and captured memory doubleword.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= req_eff_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        write_q  <= req_write;
        err_q    <= req_err;
        cnt_q    <= '0;
      end
      if (state_q == StRdWait) begin
        cnt_q <= cnt_q + 3'd1;
        if (lat_done) rd_q <= Read_Data;
      end
    end
  end

  logic [5:0]  shamt;
  logic [63:0] size_mask, ld_shifted, ld_ext, merged;

  assign shamt      = {addr_q[2:0], 3'b000};
  assign ld_shifted = rd_q >> shamt;

  // Lane extraction/extension for loads and byte-lane merge for stores.
  always_comb begin
    size_mask = '1;
    unique case (funct3_q[1:0])
      2'b00: size_mask = 64'h0000_0000_0000_00ff;
      2'b01: size_mask = 64'h0000_0000_0000_ffff;
      2'b10: size_mask = 64'h0000_0000_ffff_ffff;
      2'b11: size_mask = '1;
    endcase
    ld_ext = '0;
    case (funct3_q)
      3'b000:  ld_ext = {{56{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_ext = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b010:  ld_ext = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      3'b011:  ld_ext = ld_shifted;
      3'b100:  ld_ext = {56'd0, ld_shifted[7:0]};
      3'b101:  ld_ext = {48'd0, ld_shifted[15:0]};
      3'b110:  ld_ext = {32'd0, ld_shifted[31:0]};
      default: ld_ext = '0;
    endcase
    // SD has a full mask, so the stale rd_q never reaches memory.
    merged = (rd_q & ~(size_mask << shamt)) | ((wdata_q & size_mask) << shamt);
  end

  // Output decode from the current state.
  always_comb begin
    req_ready  = (state_q == StIdle);
    MemRead    = (state_q == StRdWait);
    MemWrite   = (state_q == StWr);
    Mem_Addr   = {addr_q[63:3], 3'b000};
    Write_Data = (state_q == StWr) ? merged : '0;
    resp_valid = (state_q == StResp);
    resp_err   = (state_q == StResp) && err_q;
    resp_rdata = ((state_q == StResp) && !write_q && !err_q) ? ld_ext : '0;
  end

endmodule
